// File: rtl/fadd_pipe.sv
// fadd_pipe: IEEE-754 binary32 add/subtract with configurable latency,
// single-occupancy or fully pipelined issue on the order/accepted/done handshake.
module fadd_pipe #(
    parameter int unsigned LATENCY   = 3,
    parameter int unsigned PIPELINED = 0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        order,
    input  logic        sub,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        accepted,
    output logic        done,
    output logic [31:0] rd,
    output logic        ovf
);

    localparam int unsigned MAN_W = 24;          // mantissa incl. hidden bit
    localparam int unsigned EXT_W = MAN_W + 3;   // mantissa + guard/round/sticky
    localparam int unsigned AL_W  = MAN_W + 34;  // alignment window, covers shift of 31

    if (LATENCY == 0 || LATENCY > 4) begin : g_bad_latency
        $error("fadd_pipe: LATENCY must be 1..4, got %0d", LATENCY);
    end

    // Datapath signals (combinational from the live operands, captured on accept)
    logic              sa, sb, nan_a, nan_b, inf_a, inf_b, swap, s_big, eff_sub;
    logic [7:0]        ea, eb, ea_eff, eb_eff, e_big, e_sml, diff;
    logic [MAN_W-1:0]  m_big, m_sml;
    logic [4:0]        shamt, lz, lsh;
    logic [AL_W-1:0]   al;
    logic [EXT_W-1:0]  big_x, sml_x, nrm;
    logic [EXT_W:0]    sum;
    logic [8:0]        e9, e_nrm, e_fld;
    logic              rnd;
    logic [31:0]       packed_r;
    logic [31:0]       res_c;
    logic              ovf_c;

    // Pipeline state: one-hot in single-occupancy mode, so it doubles as the run counter
    logic [LATENCY-1:0] vld;
    logic [LATENCY-1:0] ovf_q;
    logic [31:0]        rd_q [LATENCY];
    logic               busy;

    assign busy     = |vld;
    assign done     = vld[LATENCY-1];
    assign rd       = rd_q[LATENCY-1];
    assign ovf      = ovf_q[LATENCY-1];
    assign accepted = order & rstn & ((PIPELINED != 0) | ~busy | done);

    // Align, add/subtract, normalise, round to nearest even, then special-case overrides
    always_comb begin
        sa      = rs1[31];
        sb      = rs2[31] ^ sub;
        ea      = rs1[30:23];
        eb      = rs2[30:23];
        nan_a   = (&ea) & (|rs1[22:0]);
        nan_b   = (&eb) & (|rs2[22:0]);
        inf_a   = (&ea) & ~(|rs1[22:0]);
        inf_b   = (&eb) & ~(|rs2[22:0]);
        ea_eff  = (ea == 8'd0) ? 8'd1 : ea;
        eb_eff  = (eb == 8'd0) ? 8'd1 : eb;
        swap    = rs2[30:0] > rs1[30:0];
        e_big   = swap ? eb_eff : ea_eff;
        e_sml   = swap ? ea_eff : eb_eff;
        m_big   = swap ? {eb != 8'd0, rs2[22:0]} : {ea != 8'd0, rs1[22:0]};
        m_sml   = swap ? {ea != 8'd0, rs1[22:0]} : {eb != 8'd0, rs2[22:0]};
        s_big   = swap ? sb : sa;
        eff_sub = sa ^ sb;
        diff    = e_big - e_sml;
        shamt   = (diff > 8'd31) ? 5'd31 : diff[4:0];
        al      = {m_sml, 34'd0} >> shamt;
        sml_x   = {al[AL_W-1:32], |al[31:0]};
        big_x   = {m_big, 3'b000};
        sum     = eff_sub ? ({1'b0, big_x} - {1'b0, sml_x})
                          : ({1'b0, big_x} + {1'b0, sml_x});
        lz      = 5'(EXT_W);
        for (int i = 0; i < int'(EXT_W); i++) begin
            if (sum[i]) lz = 5'(int'(EXT_W) - 1 - i);
        end
        e9      = {1'b0, e_big};
        lsh     = 5'd0;
        if (sum[EXT_W]) begin
            nrm   = {sum[EXT_W:2], sum[1] | sum[0]};
            e_nrm = e9 + 9'd1;
        end else begin
            // Normalise no further than the minimum exponent; below that the result is subnormal
            lsh   = (9'(lz) < (e9 - 9'd1)) ? lz : 5'(e9 - 9'd1);
            nrm   = sum[EXT_W-1:0] << lsh;
            e_nrm = e9 - 9'(lsh);
        end
        e_fld    = nrm[EXT_W-1] ? e_nrm : 9'd0;
        rnd      = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
        packed_r = {e_fld, nrm[EXT_W-2:3]} + 32'(rnd);
        ovf_c    = 1'b0;
        if (sum == '0) begin
            res_c = {sa & sb, 31'd0};
        end else if (packed_r[31:23] >= 9'd255) begin
            res_c = {s_big, 8'hFF, 23'd0};
            ovf_c = 1'b1;
        end else begin
            res_c = {s_big, packed_r[30:0]};
        end
        if (nan_a || nan_b) begin
            res_c = 32'h7FC0_0000;
            ovf_c = 1'b0;
        end else if (inf_a && inf_b) begin
            res_c = (sa == sb) ? {sa, 8'hFF, 23'd0} : 32'h7FC0_0000;
            ovf_c = 1'b0;
        end else if (inf_a) begin
            res_c = {sa, 8'hFF, 23'd0};
            ovf_c = 1'b0;
        end else if (inf_b) begin
            res_c = {sb, 8'hFF, 23'd0};
            ovf_c = 1'b0;
        end
    end

    // Result shift register: data only moves behind a valid bit, so rd/ovf hold between dones
    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld   <= '0;
            ovf_q <= '0;
            for (int i = 0; i < int'(LATENCY); i++) rd_q[i] <= '0;
        end else begin
            vld[0] <= accepted;
            if (accepted) begin
                rd_q[0]  <= res_c;
                ovf_q[0] <= ovf_c;
            end
            for (int i = 1; i < int'(LATENCY); i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) begin
                    rd_q[i]  <= rd_q[i-1];
                    ovf_q[i] <= ovf_q[i-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_fadd_pipe.sv
// tb_fadd_pipe: four single-occupancy units (LATENCY 1..4) and one pipelined
// LATENCY=3 unit share one stimulus; results checked against a real-arithmetic model.
module tb_fadd_pipe;

    logic        clk = 1'b0;
    logic        rstn, order, sub;
    logic [31:0] rs1, rs2;
    logic [3:0]  acc_v, done_v, ovf_v;
    logic [31:0] rd_v [4];
    logic        acc_p, done_p, ovf_p;
    logic [31:0] rd_p;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        fadd_pipe #(.LATENCY(g + 1), .PIPELINED(0)) u_dut (
            .clk(clk), .rstn(rstn), .order(order), .sub(sub), .rs1(rs1), .rs2(rs2),
            .accepted(acc_v[g]), .done(done_v[g]), .rd(rd_v[g]), .ovf(ovf_v[g])
        );
    end

    fadd_pipe #(.LATENCY(3), .PIPELINED(1)) u_pipe (
        .clk(clk), .rstn(rstn), .order(order), .sub(sub), .rs1(rs1), .rs2(rs2),
        .accepted(acc_p), .done(done_p), .rd(rd_p), .ovf(ovf_p)
    );

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d]: observed %h expected %h", tag, idx, obs, exp);
        end
    endtask

    // ---------------- reference model: exact real sum, then IEEE rounding ----------------
    function automatic real p2(input int n);
        real r = 1.0;
        if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
        else        for (int i = 0; i < -n; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real f2r(input logic [31:0] x);
        int  e = int'(x[30:23]);
        real m = real'(int'({x[30:23] != 8'd0, x[22:0]}));
        real v;
        if (e == 0) e = 1;
        v = m * p2(e - 150);
        return x[31] ? -v : v;
    endfunction

    function automatic logic [32:0] r2f(input real xin, input logic zs);
        real x, q, f;
        int  e, fi, be;
        logic sg;
        if (xin == 0.0) return {1'b0, zs, 31'd0};
        sg = (xin < 0.0);
        x  = sg ? -xin : xin;
        e  = 0;
        while (x >= 2.0) begin x = x / 2.0; e++; end
        while (x < 1.0)  begin x = x * 2.0; e--; end
        q = (e < -126) ? x * p2(e + 149) : x * p2(23);
        f = $floor(q);
        if ((q - f) > 0.5 || ((q - f) == 0.5 && ($rtoi(f) % 2) == 1)) f = f + 1.0;
        fi = $rtoi(f);
        if (e < -126) return {1'b0, sg, 31'(fi)};
        if (fi == (1 << 24)) begin fi = 1 << 23; e++; end
        be = e + 127;
        if (be >= 255) return {1'b1, sg, 8'hFF, 23'd0};
        return {1'b0, sg, 8'(be), 23'(fi)};
    endfunction

    // Returns {ovf, rd}
    function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic sbe   = b[31] ^ s;
        logic nan_a = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        logic nan_b = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        logic inf_a = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        logic inf_b = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        real  x;
        if (nan_a || nan_b) return {1'b0, 32'h7FC0_0000};
        if (inf_a && inf_b) return (a[31] == sbe) ? {1'b0, a[31], 8'hFF, 23'd0} : {1'b0, 32'h7FC0_0000};
        if (inf_a) return {1'b0, a[31], 8'hFF, 23'd0};
        if (inf_b) return {1'b0, sbe, 8'hFF, 23'd0};
        x = s ? (f2r(a) - f2r(b)) : (f2r(a) + f2r(b));
        return r2f(x, a[31] & sbe);
    endfunction

    function automatic logic [31:0] rnd_op(input logic [31:0] near);
        logic [31:0] r = $urandom;
        case ($urandom_range(0, 5))
            0, 1:    return r;
            2:       return {r[31], 8'(near[30:23] + 8'($urandom_range(0, 3))), r[22:0]};
            3:       return {r[31], 8'd0, r[22:0]};
            4:       return {r[31], 8'(250 + $urandom_range(0, 4)), r[22:0]};
            default: return {r[31], 8'hFF, (r[0] ? 23'd0 : r[22:0])};
        endcase
    endfunction

    // One isolated op: all five units accept it; each signals done only at its latency
    task automatic issue_one(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [32:0] exp);
        order = 1'b1; rs1 = a; rs2 = b; sub = s;
        #1;
        for (int g = 0; g < 4; g++) chk("acc", g, 32'(acc_v[g]), 32'd1);
        chk("acc_p", 0, 32'(acc_p), 32'd1);
        @(negedge clk);
        order = 1'b0; rs1 = $urandom; rs2 = $urandom; sub = 1'($urandom);
        for (int c = 1; c <= 4; c++) begin
            for (int g = 0; g < 4; g++) begin
                chk("done", g, 32'(done_v[g]), 32'(c == g + 1));
                if (c == g + 1) begin
                    chk("rd", g, rd_v[g], exp[31:0]);
                    chk("ovf", g, 32'(ovf_v[g]), 32'(exp[32]));
                end
            end
            chk("done_p", c, 32'(done_p), 32'(c == 3));
            if (c == 3) begin
                chk("rd_p", 0, rd_p, exp[31:0]);
                chk("ovf_p", 0, 32'(ovf_p), 32'(exp[32]));
            end
            @(negedge clk);
        end
    endtask

    // Back-to-back issue into the pipelined unit; results must come out in order
    task automatic stream(input int n);
        logic [32:0] q[$];
        logic [32:0] e;
        for (int k = 0; k < n + 4; k++) begin
            chk("s_done", k, 32'(done_p), 32'(k >= 3 && k < n + 3));
            if (done_p) begin
                e = (q.size() > 0) ? q.pop_front() : 33'h0_DEAD_BEEF;
                chk("s_rd", k, rd_p, e[31:0]);
                chk("s_ovf", k, 32'(ovf_p), 32'(e[32]));
            end
            if (k < n) begin
                order = 1'b1; rs1 = rnd_op($urandom); rs2 = rnd_op(rs1); sub = 1'($urandom);
                q.push_back(ref_add(rs1, rs2, sub));
                #1;
                chk("s_acc", k, 32'(acc_p), 32'd1);
            end else begin
                order = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic drain();
        order = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    logic [31:0] da [13] = '{32'h3F800000, 32'h3F800000, 32'h80000000, 32'h80000000, 32'h3F800000,
                             32'h3F800001, 32'h3F800000, 32'h7F7FFFFF, 32'h7F800000, 32'h7FC00001,
                             32'h00000001, 32'h00800000, 32'h00400000};
    logic [31:0] db [13] = '{32'h40000000, 32'h3F800000, 32'h80000000, 32'h00000000, 32'h33800000,
                             32'h33800000, 32'h33800001, 32'h7F7FFFFF, 32'hFF800000, 32'h3F800000,
                             32'h00000001, 32'h00000001, 32'h00400000};
    logic        ds [13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [32:0] de [13] = '{33'h0_40400000, 33'h0_00000000, 33'h0_80000000, 33'h0_80000000,
                             33'h0_3F800000, 33'h0_3F800002, 33'h0_3F800001, 33'h1_7F800000,
                             33'h0_7FC00000, 33'h0_7FC00000, 33'h0_00000002, 33'h0_007FFFFF,
                             33'h0_00800000};

    initial begin
        logic [31:0] a, b;
        logic        s;
        logic [32:0] q3[$];
        logic [32:0] e;

        // Reset: accepted must be low while rstn=0 even with order high
        rstn = 1'b0; order = 1'b1; sub = 1'b0; rs1 = 32'h3F800000; rs2 = 32'h40000000;
        #1;
        for (int g = 0; g < 4; g++) chk("rst_acc", g, 32'(acc_v[g]), 32'd0);
        chk("rst_acc_p", 0, 32'(acc_p), 32'd0);
        @(negedge clk); @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            chk("rst_done", g, 32'(done_v[g]), 32'd0);
            chk("rst_rd", g, rd_v[g], 32'd0);
            chk("rst_ovf", g, 32'(ovf_v[g]), 32'd0);
        end
        rstn = 1'b1; order = 1'b0;
        @(negedge clk);

        // Directed vectors on every latency
        for (int i = 0; i < 13; i++) issue_one(da[i], db[i], ds[i], de[i]);

        // Randomised isolated ops against the model
        for (int i = 0; i < 120; i++) begin
            a = rnd_op($urandom); b = rnd_op(a); s = 1'($urandom);
            issue_one(a, b, s, ref_add(a, b, s));
        end

        // Pipelined: four back-to-back, then a long random stream
        stream(4);
        drain();
        stream(40);
        drain();

        // Single-occupancy LATENCY=3 with order held: accepts at 0,3,6 overlapping done
        for (int k = 0; k < 10; k++) begin
            chk("np_done", k, 32'(done_v[2]), 32'(k >= 3 && k % 3 == 0));
            if (done_v[2]) begin
                e = (q3.size() > 0) ? q3.pop_front() : 33'h0_DEAD_BEEF;
                chk("np_rd", k, rd_v[2], e[31:0]);
            end
            if (k < 9) begin
                order = 1'b1; rs1 = rnd_op($urandom); rs2 = rnd_op(rs1); sub = 1'($urandom);
                #1;
                chk("np_acc", k, 32'(acc_v[2]), 32'(k % 3 == 0));
                if (acc_v[2]) q3.push_back(ref_add(rs1, rs2, sub));
            end else begin
                order = 1'b0;
            end
            @(negedge clk);
        end
        drain();

        // Reset in cycle 1 discards the op accepted in cycle 0
        order = 1'b1; rs1 = 32'h3F800000; rs2 = 32'h40000000; sub = 1'b0;
        #1;
        chk("ra_acc", 2, 32'(acc_v[2]), 32'd1);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("ra_acc_rst", 2, 32'(acc_v[2]), 32'd0);
        chk("ra_acc_rst_p", 0, 32'(acc_p), 32'd0);
        @(negedge clk);
        rstn = 1'b1; order = 1'b0;
        for (int k = 2; k < 8; k++) begin
            for (int g = 1; g < 4; g++) chk("ra_done", g, 32'(done_v[g]), 32'd0);
            chk("ra_done_p", k, 32'(done_p), 32'd0);
            chk("ra_rd", k, rd_v[2], 32'd0);
            chk("ra_rd_p", k, rd_p, 32'd0);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
